// File: rtl/cpu6502_pkg.sv
// Shared types for the 6502 load/store/ALU core: FSM states, addressing
// modes, ALU ops, register selects, status bit positions and decode record.
package cpu6502_pkg;

    typedef enum logic [2:0] {
        S_FETCH, S_OP_LO, S_OP_HI, S_FIX, S_ZPIDX, S_READ, S_WRITE, S_EXEC
    } state_e;

    typedef enum logic [2:0] {
        M_IMM, M_ZP, M_ZPX, M_ZPY, M_ABS, M_ABSX, M_ABSY, M_IMPL
    } mode_e;

    typedef enum logic [2:0] {
        ALU_PASS, ALU_ADC, ALU_AND, ALU_ORA, ALU_EOR
    } alu_op_e;

    typedef enum logic [1:0] {
        R_A, R_X, R_Y
    } reg_sel_e;

    // What the instruction does once its operand is known
    typedef enum logic [2:0] {
        K_NOP, K_LOAD, K_STORE, K_ALU, K_CLC, K_SEC, K_CLV
    } kind_e;

    localparam int P_C = 0;
    localparam int P_Z = 1;
    localparam int P_I = 2;
    localparam int P_D = 3;
    localparam int P_B = 4;
    localparam int P_U = 5;
    localparam int P_V = 6;
    localparam int P_N = 7;

    typedef struct packed {
        kind_e    kind;
        mode_e    mode;
        alu_op_e  op;
        reg_sel_e rsel;
    } dec_t;

    function automatic dec_t mk_dec(kind_e k, mode_e m, alu_op_e o, reg_sel_e r);
        dec_t d;
        d.kind = k;
        d.mode = m;
        d.op   = o;
        d.rsel = r;
        return d;
    endfunction

    // The accumulator ALU group encodes its operation in opcode[7:5]
    function automatic alu_op_e alu_grp(logic [7:0] opc);
        case (opc[7:5])
            3'b000:  return ALU_ORA;
            3'b001:  return ALU_AND;
            3'b010:  return ALU_EOR;
            default: return ALU_ADC;
        endcase
    endfunction

endpackage

// File: rtl/cpu6502_alu.sv
// Combinational 8-bit ALU: pass-through for loads, binary ADC and logic ops.
module cpu6502_alu
    import cpu6502_pkg::*;
(
    input  logic [2:0] op_i,
    input  logic [7:0] a_i,
    input  logic [7:0] m_i,
    input  logic       c_i,
    output logic [7:0] result_o,
    output logic       n_o,
    output logic       z_o,
    output logic       c_o,
    output logic       v_o
);

    logic [8:0] sum;
    assign sum = {1'b0, a_i} + {1'b0, m_i} + {8'h00, c_i};

    // Result select; carry and overflow only meaningful for ADC
    always_comb begin
        result_o = m_i;
        c_o      = c_i;
        v_o      = 1'b0;
        case (op_i)
            ALU_ADC: begin
                result_o = sum[7:0];
                c_o      = sum[8];
                v_o      = (a_i[7] == m_i[7]) && (sum[7] != a_i[7]);
            end
            ALU_AND: result_o = a_i & m_i;
            ALU_ORA: result_o = a_i | m_i;
            ALU_EOR: result_o = a_i ^ m_i;
            default: result_o = m_i;
        endcase
    end

    assign n_o = result_o[7];
    assign z_o = (result_o == 8'h00);

endmodule

// File: rtl/cpu6502_ldst_alu_core.sv
// 6502 execution core for loads, stores and accumulator ALU ops.
// ab is registered and di is read data for the current ab; the register
// writeback of a load/ALU op happens in EXEC, which is also the next fetch.
module cpu6502_ldst_alu_core
    import cpu6502_pkg::*;
#(
    parameter logic [15:0] RESET_PC           = 16'h0000,
    parameter int          PAGE_CROSS_PENALTY = 1,
    parameter int          ZP_WRAP            = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rdy_i,
    input  logic [7:0]  di_i,
    output logic [15:0] ab_o,
    output logic [7:0]  do_o,
    output logic        we_o,
    output logic        sync_o,
    output logic [7:0]  a_o,
    output logic [7:0]  x_o,
    output logic [7:0]  y_o,
    output logic [7:0]  p_o
);

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d, ab_q, ab_d, ea_q, ea_d;
    logic [7:0]  do_q, do_d, ir_q, ir_d, lo_q, lo_d, m_q, m_d;
    logic [7:0]  a_q, a_d, x_q, x_d, y_q, y_d;
    logic        we_q, we_d, n_q, n_d, v_q, v_d, z_q, z_d, c_q, c_d;

    dec_t        dec;
    logic [7:0]  idx, src;
    logic [8:0]  zp_sum;
    logic [15:0] zp_ea, abs_ea, tgt;
    logic        page_x, is_store, go_ea;
    logic [7:0]  alu_res;
    logic        alu_n, alu_z, alu_c, alu_v;

    cpu6502_alu u_alu (
        .op_i     (dec.op),
        .a_i      (a_q),
        .m_i      (m_q),
        .c_i      (c_q),
        .result_o (alu_res),
        .n_o      (alu_n),
        .z_o      (alu_z),
        .c_o      (alu_c),
        .v_o      (alu_v)
    );

    // Opcode decode table; anything not listed is a 2-cycle NOP
    always_comb begin
        dec = mk_dec(K_NOP, M_IMPL, ALU_PASS, R_A);
        case (ir_q)
            8'hA9: dec = mk_dec(K_LOAD, M_IMM,  ALU_PASS, R_A);
            8'hA5: dec = mk_dec(K_LOAD, M_ZP,   ALU_PASS, R_A);
            8'hB5: dec = mk_dec(K_LOAD, M_ZPX,  ALU_PASS, R_A);
            8'hAD: dec = mk_dec(K_LOAD, M_ABS,  ALU_PASS, R_A);
            8'hBD: dec = mk_dec(K_LOAD, M_ABSX, ALU_PASS, R_A);
            8'hB9: dec = mk_dec(K_LOAD, M_ABSY, ALU_PASS, R_A);
            8'hA2: dec = mk_dec(K_LOAD, M_IMM,  ALU_PASS, R_X);
            8'hA6: dec = mk_dec(K_LOAD, M_ZP,   ALU_PASS, R_X);
            8'hB6: dec = mk_dec(K_LOAD, M_ZPY,  ALU_PASS, R_X);
            8'hAE: dec = mk_dec(K_LOAD, M_ABS,  ALU_PASS, R_X);
            8'hBE: dec = mk_dec(K_LOAD, M_ABSY, ALU_PASS, R_X);
            8'hA0: dec = mk_dec(K_LOAD, M_IMM,  ALU_PASS, R_Y);
            8'hA4: dec = mk_dec(K_LOAD, M_ZP,   ALU_PASS, R_Y);
            8'hB4: dec = mk_dec(K_LOAD, M_ZPX,  ALU_PASS, R_Y);
            8'hAC: dec = mk_dec(K_LOAD, M_ABS,  ALU_PASS, R_Y);
            8'hBC: dec = mk_dec(K_LOAD, M_ABSX, ALU_PASS, R_Y);
            8'h85: dec = mk_dec(K_STORE, M_ZP,   ALU_PASS, R_A);
            8'h95: dec = mk_dec(K_STORE, M_ZPX,  ALU_PASS, R_A);
            8'h8D: dec = mk_dec(K_STORE, M_ABS,  ALU_PASS, R_A);
            8'h9D: dec = mk_dec(K_STORE, M_ABSX, ALU_PASS, R_A);
            8'h99: dec = mk_dec(K_STORE, M_ABSY, ALU_PASS, R_A);
            8'h86: dec = mk_dec(K_STORE, M_ZP,   ALU_PASS, R_X);
            8'h96: dec = mk_dec(K_STORE, M_ZPY,  ALU_PASS, R_X);
            8'h8E: dec = mk_dec(K_STORE, M_ABS,  ALU_PASS, R_X);
            8'h84: dec = mk_dec(K_STORE, M_ZP,   ALU_PASS, R_Y);
            8'h94: dec = mk_dec(K_STORE, M_ZPX,  ALU_PASS, R_Y);
            8'h8C: dec = mk_dec(K_STORE, M_ABS,  ALU_PASS, R_Y);
            8'h69, 8'h29, 8'h09, 8'h49: dec = mk_dec(K_ALU, M_IMM,  alu_grp(ir_q), R_A);
            8'h65, 8'h25, 8'h05, 8'h45: dec = mk_dec(K_ALU, M_ZP,   alu_grp(ir_q), R_A);
            8'h75, 8'h35, 8'h15, 8'h55: dec = mk_dec(K_ALU, M_ZPX,  alu_grp(ir_q), R_A);
            8'h6D, 8'h2D, 8'h0D, 8'h4D: dec = mk_dec(K_ALU, M_ABS,  alu_grp(ir_q), R_A);
            8'h7D, 8'h3D, 8'h1D, 8'h5D: dec = mk_dec(K_ALU, M_ABSX, alu_grp(ir_q), R_A);
            8'h79, 8'h39, 8'h19, 8'h59: dec = mk_dec(K_ALU, M_ABSY, alu_grp(ir_q), R_A);
            8'h18: dec = mk_dec(K_CLC, M_IMPL, ALU_PASS, R_A);
            8'h38: dec = mk_dec(K_SEC, M_IMPL, ALU_PASS, R_A);
            8'hB8: dec = mk_dec(K_CLV, M_IMPL, ALU_PASS, R_A);
            default: dec = mk_dec(K_NOP, M_IMPL, ALU_PASS, R_A);
        endcase
    end

    assign idx      = (dec.mode == M_ZPY || dec.mode == M_ABSY) ? y_q : x_q;
    assign src      = (dec.rsel == R_X) ? x_q : (dec.rsel == R_Y) ? y_q : a_q;
    assign is_store = (dec.kind == K_STORE);
    assign zp_sum   = {1'b0, lo_q} + {1'b0, idx};
    assign zp_ea    = (ZP_WRAP != 0) ? {8'h00, zp_sum[7:0]} : {7'h00, zp_sum};
    assign abs_ea   = {di_i, lo_q} + {8'h00, idx};
    assign page_x   = (abs_ea[15:8] != di_i);

    // Next-state, bus and register-update logic
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ab_d    = ab_q;
        ea_d    = ea_q;
        do_d    = do_q;
        we_d    = 1'b0;
        ir_d    = ir_q;
        lo_d    = lo_q;
        m_d     = m_q;
        a_d     = a_q;
        x_d     = x_q;
        y_d     = y_q;
        n_d     = n_q;
        v_d     = v_q;
        z_d     = z_q;
        c_d     = c_q;
        go_ea   = 1'b0;
        tgt     = ea_q;
        case (state_q)
            S_FETCH, S_EXEC: begin
                if (state_q == S_EXEC) begin
                    if (dec.kind == K_LOAD) begin
                        case (dec.rsel)
                            R_X:     x_d = alu_res;
                            R_Y:     y_d = alu_res;
                            default: a_d = alu_res;
                        endcase
                        n_d = alu_n;
                        z_d = alu_z;
                    end else if (dec.kind == K_ALU) begin
                        a_d = alu_res;
                        n_d = alu_n;
                        z_d = alu_z;
                        if (dec.op == ALU_ADC) begin
                            c_d = alu_c;
                            v_d = alu_v;
                        end
                    end
                end
                ir_d    = di_i;
                pc_d    = pc_q + 16'd1;
                ab_d    = pc_q + 16'd1;
                state_d = S_OP_LO;
            end
            S_OP_LO: begin
                case (dec.mode)
                    M_IMPL: begin
                        // dummy read of the next byte, which is not consumed
                        ab_d    = pc_q;
                        state_d = S_FETCH;
                        if (dec.kind == K_CLC) c_d = 1'b0;
                        if (dec.kind == K_SEC) c_d = 1'b1;
                        if (dec.kind == K_CLV) v_d = 1'b0;
                    end
                    M_IMM: begin
                        m_d     = di_i;
                        pc_d    = pc_q + 16'd1;
                        ab_d    = pc_q + 16'd1;
                        state_d = S_EXEC;
                    end
                    M_ZP: begin
                        pc_d  = pc_q + 16'd1;
                        tgt   = {8'h00, di_i};
                        go_ea = 1'b1;
                    end
                    M_ZPX, M_ZPY: begin
                        // dummy read at the unindexed zp address
                        pc_d    = pc_q + 16'd1;
                        lo_d    = di_i;
                        ab_d    = {8'h00, di_i};
                        state_d = S_ZPIDX;
                    end
                    default: begin
                        pc_d    = pc_q + 16'd1;
                        lo_d    = di_i;
                        ab_d    = pc_q + 16'd1;
                        state_d = S_OP_HI;
                    end
                endcase
            end
            S_OP_HI: begin
                pc_d = pc_q + 16'd1;
                if (dec.mode == M_ABS) begin
                    tgt   = {di_i, lo_q};
                    go_ea = 1'b1;
                end else if (is_store || (PAGE_CROSS_PENALTY != 0 && page_x)) begin
                    // dummy read with the uncorrected high byte
                    ea_d    = abs_ea;
                    ab_d    = {di_i, abs_ea[7:0]};
                    state_d = S_FIX;
                end else begin
                    tgt   = abs_ea;
                    go_ea = 1'b1;
                end
            end
            S_ZPIDX: begin
                tgt   = zp_ea;
                go_ea = 1'b1;
            end
            S_FIX: begin
                tgt   = ea_q;
                go_ea = 1'b1;
            end
            S_READ: begin
                m_d     = di_i;
                ab_d    = pc_q;
                state_d = S_EXEC;
            end
            S_WRITE: begin
                ab_d    = pc_q;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
        if (go_ea) begin
            ab_d = tgt;
            if (is_store) begin
                we_d    = 1'b1;
                do_d    = src;
                state_d = S_WRITE;
            end else begin
                state_d = S_READ;
            end
        end
    end

    // State register; rdy low freezes everything, including we/do/ab
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ab_q    <= RESET_PC;
            ea_q    <= 16'h0000;
            do_q    <= 8'h00;
            we_q    <= 1'b0;
            ir_q    <= 8'h00;
            lo_q    <= 8'h00;
            m_q     <= 8'h00;
            a_q     <= 8'h00;
            x_q     <= 8'h00;
            y_q     <= 8'h00;
            n_q     <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
        end else if (rdy_i) begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ab_q    <= ab_d;
            ea_q    <= ea_d;
            do_q    <= do_d;
            we_q    <= we_d;
            ir_q    <= ir_d;
            lo_q    <= lo_d;
            m_q     <= m_d;
            a_q     <= a_d;
            x_q     <= x_d;
            y_q     <= y_d;
            n_q     <= n_d;
            v_q     <= v_d;
            z_q     <= z_d;
            c_q     <= c_d;
        end
    end

    // Status byte with the constant bits filled in
    always_comb begin
        p_o      = 8'h00;
        p_o[P_N] = n_q;
        p_o[P_V] = v_q;
        p_o[P_U] = 1'b1;
        p_o[P_B] = 1'b1;
        p_o[P_D] = 1'b0;
        p_o[P_I] = 1'b1;
        p_o[P_Z] = z_q;
        p_o[P_C] = c_q;
    end

    assign ab_o   = ab_q;
    assign do_o   = do_q;
    assign we_o   = we_q;
    assign sync_o = (state_q == S_FETCH) || (state_q == S_EXEC);
    assign a_o    = a_q;
    assign x_o    = x_q;
    assign y_o    = y_q;

endmodule

// File: tb/tb_cpu6502_ldst_alu_core.sv
// Directed bench: two cores share one memory; dut0 uses default parameters,
// dut1 has no page-cross penalty and no zero-page wrap.
module tb_cpu6502_ldst_alu_core;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rdy = 1'b1;
    logic [7:0]  di0, di1, do0, do1, a0, x0, y0, p0, a1, x1, y1, p1;
    logic [15:0] ab0, ab1;
    logic        we0, we1, sync0, sync1;
    logic [7:0]  mem [0:65535];
    int          checks = 0;
    int          failures = 0;
    int          wr_cnt;

    always #5 clk = ~clk;

    assign di0 = mem[ab0];
    assign di1 = mem[ab1];

    cpu6502_ldst_alu_core #(.RESET_PC(16'h0000), .PAGE_CROSS_PENALTY(1), .ZP_WRAP(1)) dut0 (
        .clk(clk), .reset(reset), .rdy_i(rdy), .di_i(di0), .ab_o(ab0), .do_o(do0),
        .we_o(we0), .sync_o(sync0), .a_o(a0), .x_o(x0), .y_o(y0), .p_o(p0));

    cpu6502_ldst_alu_core #(.RESET_PC(16'h0000), .PAGE_CROSS_PENALTY(0), .ZP_WRAP(0)) dut1 (
        .clk(clk), .reset(reset), .rdy_i(rdy), .di_i(di1), .ab_o(ab1), .do_o(do1),
        .we_o(we1), .sync_o(sync1), .a_o(a1), .x_o(x1), .y_o(y1), .p_o(p1));

    // Count bus writes of dut0 as memory would see them
    always @(posedge clk or posedge reset) begin
        if (reset) wr_cnt <= 0;
        else if (rdy && we0) wr_cnt <= wr_cnt + 1;
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic prep();
        reset = 1'b1;
        rdy   = 1'b1;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    endtask

    // Release reset between edges; the following cycle is cycle 1
    task automatic go();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        prep();
        mem[0] = 8'hA9; mem[1] = 8'h7F; mem[2] = 8'h69; mem[3] = 8'h01;
        step(2);
        checks++; if (ab0 !== 16'h0000) begin failures++; $display("FAIL rst_ab got=%h exp=0000", ab0); end
        checks++; if (we0 !== 1'b0) begin failures++; $display("FAIL rst_we got=%b exp=0", we0); end
        checks++; if (do0 !== 8'h00) begin failures++; $display("FAIL rst_do got=%h exp=00", do0); end
        checks++; if (sync0 !== 1'b1) begin failures++; $display("FAIL rst_sync got=%b exp=1", sync0); end
        checks++; if ({a0, x0, y0} !== 24'h0) begin failures++; $display("FAIL rst_axy got=%h exp=000000", {a0, x0, y0}); end
        checks++; if (p0 !== 8'h34) begin failures++; $display("FAIL rst_p got=%h exp=34", p0); end
    endtask

    task automatic test_adc_overflow();
        prep();
        mem[0] = 8'hA9; mem[1] = 8'h7F; mem[2] = 8'h69; mem[3] = 8'h01;
        go();
        checks++; if (sync0 !== 1'b1 || ab0 !== 16'h0000) begin failures++; $display("FAIL adc_c1 got=%b/%h exp=1/0000", sync0, ab0); end
        step(1);
        checks++; if (sync0 !== 1'b0 || ab0 !== 16'h0001) begin failures++; $display("FAIL adc_c2 got=%b/%h exp=0/0001", sync0, ab0); end
        step(1);
        checks++; if (sync0 !== 1'b1 || ab0 !== 16'h0002) begin failures++; $display("FAIL adc_fetch2 got=%b/%h exp=1/0002", sync0, ab0); end
        step(1);
        checks++; if (a0 !== 8'h7F) begin failures++; $display("FAIL adc_lda got=%h exp=7F", a0); end
        step(2);
        checks++; if (a0 !== 8'h80) begin failures++; $display("FAIL adc_a got=%h exp=80", a0); end
        checks++; if (p0 !== 8'hF4) begin failures++; $display("FAIL adc_p got=%h exp=F4", p0); end
    endtask

    task automatic test_page_cross();
        prep();
        mem[0] = 8'hA2; mem[1] = 8'hFF; mem[2] = 8'hBD; mem[3] = 8'h01; mem[4] = 8'h20;
        mem[16'h2100] = 8'h5A;
        go();
        step(5);
        checks++; if (ab0 !== 16'h2000) begin failures++; $display("FAIL pc_dummy got=%h exp=2000", ab0); end
        checks++; if (ab1 !== 16'h2100) begin failures++; $display("FAIL pc_nopen_read got=%h exp=2100", ab1); end
        step(1);
        checks++; if (ab0 !== 16'h2100 || sync0 !== 1'b0) begin failures++; $display("FAIL pc_read got=%h/%b exp=2100/0", ab0, sync0); end
        checks++; if (ab1 !== 16'h0005 || sync1 !== 1'b1) begin failures++; $display("FAIL pc_nopen_fetch got=%h/%b exp=0005/1", ab1, sync1); end
        step(1);
        checks++; if (ab0 !== 16'h0005 || sync0 !== 1'b1) begin failures++; $display("FAIL pc_fetch got=%h/%b exp=0005/1", ab0, sync0); end
        step(1);
        checks++; if (a0 !== 8'h5A || a1 !== 8'h5A) begin failures++; $display("FAIL pc_a got=%h/%h exp=5A/5A", a0, a1); end
        checks++; if (x0 !== 8'hFF || p0 !== 8'h34) begin failures++; $display("FAIL pc_xp got=%h/%h exp=FF/34", x0, p0); end
    endtask

    task automatic test_store_indexed();
        prep();
        mem[0] = 8'hA0; mem[1] = 8'h03; mem[2] = 8'hA9; mem[3] = 8'hC3;
        mem[4] = 8'h99; mem[5] = 8'h10; mem[6] = 8'h00;
        go();
        step(7);
        checks++; if (we0 !== 1'b0) begin failures++; $display("FAIL st_we_early got=%b exp=0", we0); end
        step(1);
        checks++; if (we0 !== 1'b1 || ab0 !== 16'h0013 || do0 !== 8'hC3) begin
            failures++; $display("FAIL st_write got=%b/%h/%h exp=1/0013/C3", we0, ab0, do0); end
        step(1);
        checks++; if (we0 !== 1'b0 || ab0 !== 16'h0007 || sync0 !== 1'b1) begin
            failures++; $display("FAIL st_next got=%b/%h/%b exp=0/0007/1", we0, ab0, sync0); end
        step(2);
        checks++; if (wr_cnt !== 1) begin failures++; $display("FAIL st_count got=%0d exp=1", wr_cnt); end
        checks++; if (y0 !== 8'h03 || a0 !== 8'hC3 || p0 !== 8'hB4) begin
            failures++; $display("FAIL st_regs got=%h/%h/%h exp=03/C3/B4", y0, a0, p0); end
    endtask

    task automatic test_zp_indexed();
        prep();
        mem[0] = 8'hA2; mem[1] = 8'hF0; mem[2] = 8'hB5; mem[3] = 8'h20;
        mem[16'h0010] = 8'h11; mem[16'h0110] = 8'h22; mem[16'h0020] = 8'h33;
        go();
        step(5);
        checks++; if (ab0 !== 16'h0010) begin failures++; $display("FAIL zp_wrap got=%h exp=0010", ab0); end
        checks++; if (ab1 !== 16'h0110) begin failures++; $display("FAIL zp_nowrap got=%h exp=0110", ab1); end
        step(1);
        checks++; if (ab0 !== 16'h0004 || sync0 !== 1'b1) begin failures++; $display("FAIL zp_fetch got=%h/%b exp=0004/1", ab0, sync0); end
        step(1);
        checks++; if (a0 !== 8'h11 || a1 !== 8'h22) begin failures++; $display("FAIL zp_a got=%h/%h exp=11/22", a0, a1); end
        checks++; if (p0 !== 8'h34) begin failures++; $display("FAIL zp_p got=%h exp=34", p0); end
    endtask

    task automatic test_sec_adc_nop();
        prep();
        mem[0] = 8'h38; mem[1] = 8'hA9; mem[2] = 8'hFF; mem[3] = 8'h69; mem[4] = 8'h00; mem[5] = 8'h02;
        go();
        step(1);
        checks++; if (sync0 !== 1'b0) begin failures++; $display("FAIL sec_dummy got=%b exp=0", sync0); end
        step(1);
        checks++; if (ab0 !== 16'h0001 || sync0 !== 1'b1 || p0 !== 8'h35) begin
            failures++; $display("FAIL sec_fetch got=%h/%b/%h exp=0001/1/35", ab0, sync0, p0); end
        step(5);
        checks++; if (a0 !== 8'h00 || p0 !== 8'h37) begin failures++; $display("FAIL adc_carry got=%h/%h exp=00/37", a0, p0); end
        checks++; if (ab0 !== 16'h0006 || sync0 !== 1'b0) begin failures++; $display("FAIL nop_dummy got=%h/%b exp=0006/0", ab0, sync0); end
        step(1);
        checks++; if (ab0 !== 16'h0006 || sync0 !== 1'b1) begin failures++; $display("FAIL nop_fetch got=%h/%b exp=0006/1", ab0, sync0); end
        step(1);
        checks++; if ({a0, x0, y0, p0} !== 32'h0000_0037) begin
            failures++; $display("FAIL nop_regs got=%h exp=00000037", {a0, x0, y0, p0}); end
    endtask

    task automatic test_wait_and_reset();
        prep();
        mem[0] = 8'hA9; mem[1] = 8'h5A; mem[2] = 8'h8D; mem[3] = 8'h00; mem[4] = 8'hC0;
        mem[5] = 8'hAD; mem[6] = 8'h34; mem[7] = 8'h12;
        go();
        step(5);
        checks++; if (we0 !== 1'b1 || ab0 !== 16'hC000 || do0 !== 8'h5A) begin
            failures++; $display("FAIL wt_write got=%b/%h/%h exp=1/C000/5A", we0, ab0, do0); end
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            checks++; if (we0 !== 1'b1 || ab0 !== 16'hC000 || do0 !== 8'h5A) begin
                failures++; $display("FAIL wt_hold%0d got=%b/%h/%h exp=1/C000/5A", i, we0, ab0, do0); end
        end
        rdy = 1'b1;
        step(1);
        checks++; if (we0 !== 1'b0 || ab0 !== 16'h0005 || sync0 !== 1'b1) begin
            failures++; $display("FAIL wt_after got=%b/%h/%b exp=0/0005/1", we0, ab0, sync0); end
        checks++; if (wr_cnt !== 1) begin failures++; $display("FAIL wt_count got=%0d exp=1", wr_cnt); end
        step(2);
        checks++; if (ab0 !== 16'h0007) begin failures++; $display("FAIL rm_ophi got=%h exp=0007", ab0); end
        reset = 1'b1;
        #1;
        checks++; if (ab0 !== 16'h0000 || we0 !== 1'b0 || sync0 !== 1'b1) begin
            failures++; $display("FAIL rm_bus got=%h/%b/%b exp=0000/0/1", ab0, we0, sync0); end
        checks++; if ({a0, x0, y0, p0} !== 32'h0000_0034) begin
            failures++; $display("FAIL rm_regs got=%h exp=00000034", {a0, x0, y0, p0}); end
        step(1);
    endtask

    initial begin
        test_reset();
        test_adc_overflow();
        test_page_cross();
        test_store_indexed();
        test_zp_indexed();
        test_sec_adc_nop();
        test_wait_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
